// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap unit.
// Optional external interrupt support is enabled with TRAP_UNIT_IRQ_EN.
package trap_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_TRAP,
    S_RETURN
  } state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;

  localparam logic [31:0] IRQ_CAUSE = 32'h8000_000B;

endpackage

// File: rtl/trap_unit_if.sv
// Execute-stage to trap-unit bundle: trap/return requests, CSR port, redirect.
// extIrq exists only when TRAP_UNIT_IRQ_EN is defined.
interface trap_unit_if;
  logic        validE;
  logic [31:0] pcE;
  logic        exceptionE;
  logic [7:0]  exceptionCodeE;
  logic        iretE;
  logic [11:0] csrAddr;
  logic        csrWe;
  logic [31:0] csrWdata;
  logic [31:0] csrRdata;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        busy;
`ifdef TRAP_UNIT_IRQ_EN
  logic        extIrq;
`endif

  modport master (
`ifdef TRAP_UNIT_IRQ_EN
    output extIrq,
`endif
    output validE, pcE, exceptionE, exceptionCodeE,
    output iretE, csrAddr, csrWe, csrWdata,
    input  csrRdata, redirect, redirectPc, busy
  );

  modport slave (
`ifdef TRAP_UNIT_IRQ_EN
    input  extIrq,
`endif
    input  validE, pcE, exceptionE, exceptionCodeE,
    input  iretE, csrAddr, csrWe, csrWdata,
    output csrRdata, redirect, redirectPc, busy
  );

endinterface

// File: rtl/trap_csr_file.sv
// Machine trap CSRs (mstatus, mtvec, mepc, mcause, optional mie) and read mux.
// The mie register and its MEIE bit exist only with TRAP_UNIT_IRQ_EN.
module trap_csr_file
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        trap_i,
  input  logic [31:0] trap_pc_i,
  input  logic [31:0] trap_cause_i,
  input  logic        ret_i,
  input  logic        we_i,
  input  logic [11:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef TRAP_UNIT_IRQ_EN
  output logic        mie_o,
  output logic        meie_o,
`endif
  output logic [31:0] rdata_o,
  output logic [31:0] mtvec_o,
  output logic [31:0] mepc_o
);

  logic        mie_q, mie_d;
  logic        mpie_q, mpie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
`ifdef TRAP_UNIT_IRQ_EN
  logic        meie_q, meie_d;
`endif

  // Trap entry and return take precedence over software writes.
  always_comb begin
    mie_d    = mie_q;
    mpie_d   = mpie_q;
    mtvec_d  = mtvec_q;
    mepc_d   = mepc_q;
    mcause_d = mcause_q;
`ifdef TRAP_UNIT_IRQ_EN
    meie_d   = meie_q;
`endif
    if (trap_i) begin
      mepc_d   = trap_pc_i;
      mcause_d = trap_cause_i;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (ret_i) begin
      mie_d  = mpie_q;
      mpie_d = 1'b1;
    end else if (we_i) begin
      unique case (1'b1)
        (addr_i == CSR_MSTATUS): begin
          mie_d  = wdata_i[MSTATUS_MIE];
          mpie_d = wdata_i[MSTATUS_MPIE];
        end
`ifdef TRAP_UNIT_IRQ_EN
        (addr_i == CSR_MIE):
          meie_d = wdata_i[MIE_MEIE];
`endif
        (addr_i == CSR_MTVEC):
          mtvec_d = {wdata_i[31:2], 2'b00};
        (addr_i == CSR_MEPC):
          mepc_d = {wdata_i[31:2], 2'b00};
        (addr_i == CSR_MCAUSE):
          mcause_d = wdata_i;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= 32'h0;
      mcause_q <= 32'h0;
`ifdef TRAP_UNIT_IRQ_EN
      meie_q   <= 1'b0;
`endif
    end else begin
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
`ifdef TRAP_UNIT_IRQ_EN
      meie_q   <= meie_d;
`endif
    end
  end

  always_comb begin
    rdata_o = 32'h0;
    unique case (1'b1)
      (addr_i == CSR_MSTATUS): begin
        rdata_o[MSTATUS_MIE]  = mie_q;
        rdata_o[MSTATUS_MPIE] = mpie_q;
      end
`ifdef TRAP_UNIT_IRQ_EN
      (addr_i == CSR_MIE):
        rdata_o[MIE_MEIE] = meie_q;
`endif
      (addr_i == CSR_MTVEC):  rdata_o = mtvec_q;
      (addr_i == CSR_MEPC):   rdata_o = mepc_q;
      (addr_i == CSR_MCAUSE): rdata_o = mcause_q;
      default: ;
    endcase
  end

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
`ifdef TRAP_UNIT_IRQ_EN
  assign mie_o   = mie_q;
  assign meie_o  = meie_q;
`endif

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap/return sequencer: one-cycle redirect after acceptance.
// Define TRAP_UNIT_IRQ_EN to add the gated external interrupt input.
module trap_unit
  import trap_pkg::*;
#(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input logic         clk,
  input logic         rst_n,
  trap_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic        idle;
  logic        exc_take;
  logic        irq_take;
  logic        trap_take;
  logic        ret_take;
  logic        csr_we;
  logic [31:0] trap_cause;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        redirect;
  logic        busy;
  logic [31:0] redirect_pc;

  assign idle     = (state_q == S_IDLE);
  assign exc_take = idle & bus.validE & bus.exceptionE;

`ifdef TRAP_UNIT_IRQ_EN
  logic mie;
  logic meie;
  assign irq_take = idle & bus.validE & bus.extIrq & mie & meie &
                    ~bus.exceptionE;
`else
  assign irq_take = 1'b0;
`endif

  assign trap_take  = exc_take | irq_take;
  assign ret_take   = idle & bus.validE & bus.iretE & ~trap_take;
  assign csr_we     = idle & bus.validE & bus.csrWe &
                      ~trap_take & ~ret_take;
  assign trap_cause = exc_take ? {24'h0, bus.exceptionCodeE} : IRQ_CAUSE;

  trap_csr_file #(
    .MTVEC_RESET (MTVEC_RESET)
  ) u_csr (
    .clk          (clk),
    .rst_n        (rst_n),
    .trap_i       (trap_take),
    .trap_pc_i    (bus.pcE),
    .trap_cause_i (trap_cause),
    .ret_i        (ret_take),
    .we_i         (csr_we),
    .addr_i       (bus.csrAddr),
    .wdata_i      (bus.csrWdata),
`ifdef TRAP_UNIT_IRQ_EN
    .mie_o        (mie),
    .meie_o       (meie),
`endif
    .rdata_o      (bus.csrRdata),
    .mtvec_o      (mtvec),
    .mepc_o       (mepc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = S_IDLE;
    redirect    = 1'b0;
    busy        = 1'b0;
    redirect_pc = 32'h0;
    unique case (state_q)
      S_IDLE: begin
        if (trap_take)     state_d = S_TRAP;
        else if (ret_take) state_d = S_RETURN;
      end
      S_TRAP: begin
        redirect    = 1'b1;
        busy        = 1'b1;
        redirect_pc = {mtvec[31:2], 2'b00};
      end
      S_RETURN: begin
        redirect    = 1'b1;
        busy        = 1'b1;
        redirect_pc = mepc;
      end
      default: ;
    endcase
  end

  assign bus.redirect   = redirect;
  assign bus.busy       = busy;
  assign bus.redirectPc = redirect_pc;

endmodule

// File: tb/tb_trap_unit.sv
// Scoreboard bench for trap_unit: directed scenarios then random traffic.
module tb_trap_unit;
  import trap_pkg::*;

  localparam logic [31:0] MTVEC_R = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trap_unit_if bus ();

  trap_unit #(
    .MTVEC_RESET (MTVEC_R)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        redirect;
    logic        busy;
    logic [31:0] pc;
    logic [31:0] rdata;
    logic [11:0] addr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic        m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        irq_drv;

  function automatic logic [31:0] m_read(input logic [11:0] a);
    logic [31:0] r;
    r = 32'h0;
    case (a)
      12'h300: begin r[3] = m_mie; r[7] = m_mpie; end
`ifdef TRAP_UNIT_IRQ_EN
      12'h304: r[11] = m_meie;
`endif
      12'h305: r = m_mtvec;
      12'h341: r = m_mepc;
      12'h342: r = m_mcause;
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic m_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0;
    m_mtvec = MTVEC_R; m_mepc = 0; m_mcause = 0;
    m_pend = 0; m_tgt = 0;
  endtask

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [31:0] pc, input logic e,
                      input logic [7:0] code, input logic ir,
                      input logic we, input logic [11:0] a,
                      input logic [31:0] wd, input logic irq);
    exp_t x;
    logic exc, itk;
    rst_n              = r;
    bus.validE         = v;
    bus.pcE            = pc;
    bus.exceptionE     = e;
    bus.exceptionCodeE = code;
    bus.iretE          = ir;
    bus.csrWe          = we;
    bus.csrAddr        = a;
    bus.csrWdata       = wd;
    irq_drv            = irq;
`ifdef TRAP_UNIT_IRQ_EN
    bus.extIrq         = irq_drv;
`endif
    if (!r) m_reset();
    x.redirect = m_pend;
    x.busy     = m_pend;
    x.pc       = m_pend ? m_tgt : 32'h0;
    x.rdata    = m_read(a);
    x.addr     = a;
    sb.push_back(x);
    if (r) begin
      if (m_pend) begin
        m_pend = 0;
      end else begin
        exc = v && e;
        itk = 1'b0;
`ifdef TRAP_UNIT_IRQ_EN
        itk = v && irq && m_mie && m_meie && !e;
`endif
        if (exc || itk) begin
          m_mepc   = pc;
          m_mcause = exc ? {24'h0, code} : 32'h8000_000B;
          m_mpie   = m_mie;
          m_mie    = 0;
          m_pend   = 1;
          m_tgt    = {m_mtvec[31:2], 2'b00};
        end else if (v && ir) begin
          m_mie  = m_mpie;
          m_mpie = 1;
          m_pend = 1;
          m_tgt  = m_mepc;
        end else if (v && we) begin
          case (a)
            12'h300: begin m_mie = wd[3]; m_mpie = wd[7]; end
`ifdef TRAP_UNIT_IRQ_EN
            12'h304: m_meie = wd[11];
`endif
            12'h305: m_mtvec = {wd[31:2], 2'b00};
            12'h341: m_mepc = {wd[31:2], 2'b00};
            12'h342: m_mcause = wd;
            default: ;
          endcase
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic [11:0] a);
    step(1, 0, 32'h0, 0, 8'h0, 0, 0, a, 32'h0, 0);
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    step(1, 1, 32'h0, 0, 8'h0, 0, 1, a, d, 0);
  endtask

  task automatic exc(input logic [31:0] pc, input logic [7:0] c,
                     input logic [11:0] a);
    step(1, 1, pc, 1, c, 0, 0, a, 32'h0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        x = sb.pop_front();
        chk("redirect", {31'h0, bus.redirect}, {31'h0, x.redirect});
        chk("busy", {31'h0, bus.busy}, {31'h0, x.busy});
        chk("redirectPc", bus.redirectPc, x.pc);
        chk($sformatf("csrRdata[%h]", x.addr), bus.csrRdata, x.rdata);
      end
    end
  end

  initial begin : stim
    logic [11:0] addrs [7];
    logic [11:0] a;
    addrs[0] = 12'h300; addrs[1] = 12'h304; addrs[2] = 12'h305;
    addrs[3] = 12'h341; addrs[4] = 12'h342; addrs[5] = 12'h7C0;
    addrs[6] = 12'h301;
    m_reset();
    irq_drv = 0;
    bus.validE = 0; bus.pcE = 0; bus.exceptionE = 0;
    bus.exceptionCodeE = 0; bus.iretE = 0; bus.csrAddr = 0;
    bus.csrWe = 0; bus.csrWdata = 0;
`ifdef TRAP_UNIT_IRQ_EN
    bus.extIrq = 0;
`endif
    @(posedge clk);
    #1;
    step(0, 0, 0, 0, 0, 0, 0, CSR_MTVEC, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, CSR_MSTATUS, 0, 0);
    idle(CSR_MEPC);

    // mtvec low bits dropped, exception vectors there
    wr(CSR_MTVEC, 32'h0000_0103);
    exc(32'h100, 8'h0B, CSR_MTVEC);
    idle(CSR_MEPC);
    idle(CSR_MCAUSE);

    // MIE/MPIE stacking through trap and xRET
    wr(CSR_MSTATUS, 32'h8);
    exc(32'h200, 8'h02, CSR_MSTATUS);
    idle(CSR_MSTATUS);
    step(1, 1, 32'h0, 0, 8'h0, 1, 0, CSR_MSTATUS, 0, 0);
    idle(CSR_MSTATUS);
    idle(CSR_MSTATUS);

    // exception beats iret; iret during TRAP ignored
    step(1, 1, 32'h300, 1, 8'h05, 1, 0, CSR_MEPC, 0, 0);
    step(1, 1, 32'h0, 0, 8'h0, 1, 0, CSR_MEPC, 0, 0);
    idle(CSR_MCAUSE);
    idle(CSR_MEPC);

    // trap wins over same-cycle CSR write
    step(1, 1, 32'h40, 1, 8'h01, 0, 1, CSR_MEPC, 32'h207, 0);
    idle(CSR_MEPC);
    wr(CSR_MEPC, 32'h0000_0207);
    idle(CSR_MEPC);
    wr(12'h7C0, 32'hFFFF_FFFF);
    idle(12'h7C0);

    // reset in the middle of a trap
    wr(CSR_MSTATUS, 32'h88);
    exc(32'h500, 8'h03, CSR_MEPC);
    step(0, 0, 0, 0, 0, 0, 0, CSR_MEPC, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, CSR_MTVEC, 0, 0);
    idle(CSR_MSTATUS);
    idle(CSR_MCAUSE);

`ifdef TRAP_UNIT_IRQ_EN
    wr(CSR_MIE, 32'h800);
    wr(CSR_MSTATUS, 32'h8);
    step(1, 1, 32'h80, 0, 8'h0, 0, 0, CSR_MIE, 0, 1);
    idle(CSR_MCAUSE);
    idle(CSR_MEPC);
    step(1, 1, 32'h90, 0, 8'h0, 0, 0, CSR_MEPC, 0, 1);
    idle(CSR_MEPC);
`endif

    for (int i = 0; i < 3000; i++) begin
      a = addrs[$urandom_range(0, 6)];
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 7) != 0),
           $urandom,
           ($urandom_range(0, 7) == 0),
           8'($urandom),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 2) == 0),
           a,
           $urandom,
           ($urandom_range(0, 3) == 0));
    end
    idle(CSR_MSTATUS);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_unit.md
TRAP_UNIT -- requirements
Module: trap_unit

Interface
REQ-001 Parameter: MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
REQ-002 clk  in  1  core clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 validE  in  1  execute-stage slot holds a live instruction.
REQ-005 pcE  in  32  PC of execute-stage instruction.
REQ-006 exceptionE  in  1  synchronous exception raised by the execute stage.
REQ-007 exceptionCodeE  in  8  cause of exceptionE.
REQ-008 iretE  in  1  xRET decoded in the execute stage.
REQ-009 csrAddr  in  12  CSR address; csrWe in 1 write strobe; csrWdata in 32 write data.
REQ-010 csrRdata  out  32  combinational read of csrAddr.
REQ-011 redirect  out  1  fetch redirect and pipeline flush strobe.
REQ-012 redirectPc  out  32  redirect target, valid when redirect=1.
REQ-013 busy  out  1  stall request to upstream stages.

Function
REQ-014 FSM states IDLE, TRAP, RETURN; inputs sampled only in IDLE, ignored otherwise.
REQ-015 IDLE with validE&exceptionE: mepc<=pcE, mcause<={24'b0,exceptionCodeE}, MPIE<=MIE, MIE<=0, next TRAP.
REQ-016 IDLE with validE&iretE and no trap: MIE<=MPIE, MPIE<=1, next RETURN.
REQ-017 Priority on simultaneous events: exceptionE > interrupt (REQ-027) > iretE.
REQ-018 TRAP: redirect=1, busy=1, redirectPc={mtvec[31:2],2'b00}, next IDLE.
REQ-019 RETURN: redirect=1, busy=1, redirectPc=mepc, next IDLE.
REQ-020 Trap/return latency: redirect asserted exactly one cycle after the accepting edge, for exactly one cycle.
REQ-021 CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7, other bits read 0), mtvec 0x305, mepc 0x341, mcause 0x342.
REQ-022 CSR write on csrWe&validE in IDLE only; mepc bits[1:0] and mtvec bits[1:0] forced 0.
REQ-023 Same-cycle CSR write and trap/return acceptance: trap/return update wins, CSR write dropped.
REQ-024 Unimplemented csrAddr: reads 32'b0, writes ignored.
REQ-025 Outside TRAP/RETURN: redirect=0, busy=0, redirectPc=0.

Reset
REQ-026 rst_n low: state IDLE, mstatus=0, mepc=0, mcause=0, mtvec=MTVEC_RESET, redirect=0, busy=0; takes effect mid-trap, aborting any pending redirect.

Configuration
REQ-027 TRAP_UNIT_IRQ_EN defined: add input extIrq (1); IDLE with extIrq&MIE&validE&!exceptionE traps with mcause=32'h8000_000B, mepc=pcE, MIE cleared as REQ-015; mstatus/mie 0x304 (bit 11 MEIE) gates extIrq.
REQ-028 TRAP_UNIT_IRQ_EN undefined: no extIrq port, no 0x304 register (reads 0), only synchronous traps.

Structure
REQ-029 Shared package trap_pkg: state enum, CSR address constants, mstatus bit indices, interrupt cause constant.
REQ-030 One sub-module trap_csr_file holding mstatus/mtvec/mepc/mcause/mie with read mux; FSM stays in trap_unit.

Verification
REQ-031 mtvec write 0x0000_0103, then exceptionE code 8'h0B at pcE 0x100 -> next cycle redirect=1, redirectPc 0x100, mepc 0x100, mcause 0x0B.
REQ-032 MIE=1, exception accepted -> MIE=0, MPIE=1; then iretE -> next cycle redirectPc=mepc, MIE=1, MPIE=1.
REQ-033 exceptionE and iretE same cycle -> TRAP taken, RETURN never entered; iretE during TRAP ignored.
REQ-034 csrWe to mepc with data 0x0000_0207 same cycle as exception at pcE 0x40 -> mepc=0x40; separate write -> mepc reads 0x204.
REQ-035 rst_n low while in TRAP -> redirect=0 immediately, all CSRs at reset values, state IDLE after release.
REQ-036 TRAP_UNIT_IRQ_EN: MIE=1, MEIE=1, extIrq=1, pcE 0x80 -> mcause 0x8000_000B, mepc 0x80; with MIE=0 -> no trap.
